// File: rtl/bp_update_scheduler_if.sv
// Signal bundle between EX-stage branch resolution, the predictor table-update
// channel, the history-rollback pulse and the queue status of bp_update_scheduler.
interface bp_update_scheduler_if #(
  parameter int DEPTH = 4
);
  logic                     PL_stall;
  logic                     res_valid;
  logic [31:0]              res_pc;
  logic [2:0]               res_type;
  logic                     res_taken;
  logic                     res_mispredict;
  logic                     upd_valid;
  logic                     upd_ready;
  logic [31:0]              upd_pc;
  logic [2:0]               upd_type;
  logic                     upd_taken;
  logic                     rb_valid;
  logic [31:0]              rb_pc;
  logic [2:0]               rb_type;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic [7:0]               drop_cnt;
  logic                     busy;

  // master is the scheduler: it sinks resolutions and sources updates/rollbacks
  modport master (
    input  PL_stall, res_valid, res_pc, res_type, res_taken, res_mispredict, upd_ready,
    output upd_valid, upd_pc, upd_type, upd_taken, rb_valid, rb_pc, rb_type,
    output full, empty, count, drop_cnt, busy
  );

  modport slave (
    output PL_stall, res_valid, res_pc, res_type, res_taken, res_mispredict, upd_ready,
    input  upd_valid, upd_pc, upd_type, upd_taken, rb_valid, rb_pc, rb_type,
    input  full, empty, count, drop_cnt, busy
  );
endinterface

// File: rtl/bp_update_scheduler.sv
// Queues resolved B-type branches and replays them in order to the predictor
// table, inserting a rollback pulse and a quiet window after each misprediction.
module bp_update_scheduler #(
  parameter int DEPTH   = 4,
  parameter int RB_WAIT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bp_update_scheduler_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
  localparam logic [2:0]    C_RB_WAIT = 3'(RB_WAIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    ROLLBACK = 2'd2,
    HOLD     = 2'd3
  } state_t;

  function automatic logic f_type_legal(input logic [2:0] t);
    return (t <= 3'd5);
  endfunction

  state_t          r_state;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [7:0]      r_drop_cnt;
  logic [2:0]      r_hold_cnt;
  logic [DEPTH-1:0] r_q_vld;
  logic [31:0]     r_q_pc    [DEPTH];
  logic [2:0]      r_q_type  [DEPTH];
  logic            r_q_taken [DEPTH];
  logic            r_q_mis   [DEPTH];

  logic            r_upd_valid;
  logic [31:0]     r_upd_pc;
  logic [2:0]      r_upd_type;
  logic            r_upd_taken;
  logic            r_rb_valid;
  logic [31:0]     r_rb_pc;
  logic [2:0]      r_rb_type;

  logic            w_full;
  logic            w_empty;
  logic            w_res_ok;
  logic            w_deq;
  logic            w_enq;
  logic            w_drop;
  logic [AW-1:0]   w_rd_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [31:0]     w_head_pc;
  logic [2:0]      w_head_type;
  logic            w_head_taken;
  logic            w_head_mis;
  logic [31:0]     w_nxt_pc;
  logic [2:0]      w_nxt_type;
  logic            w_nxt_taken;

  assign w_full    = (r_count == C_DEPTH);
  assign w_empty   = (r_count == {CW{1'b0}});
  assign w_res_ok  = bus.res_valid && !bus.PL_stall && f_type_legal(bus.res_type);
  assign w_deq     = (r_state == ISSUE) && bus.upd_ready;
  assign w_enq     = w_res_ok && (!w_full || w_deq);
  assign w_drop    = w_res_ok && w_full && !w_deq;
  assign w_rd_nxt  = r_rd_ptr + AW'(1);
  assign w_cnt_nxt = r_count + CW'(w_enq) - CW'(w_deq);

  // Head-of-queue payload, zero for an unoccupied slot
  always_comb begin
    w_head_pc    = 32'd0;
    w_head_type  = 3'd0;
    w_head_taken = 1'b0;
    w_head_mis   = 1'b0;
    if (r_q_vld[r_rd_ptr]) begin
      w_head_pc    = r_q_pc[r_rd_ptr];
      w_head_type  = r_q_type[r_rd_ptr];
      w_head_taken = r_q_taken[r_rd_ptr];
      w_head_mis   = r_q_mis[r_rd_ptr];
    end else begin
      w_head_pc    = 32'd0;
      w_head_type  = 3'd0;
      w_head_taken = 1'b0;
      w_head_mis   = 1'b0;
    end
  end

  // Entry that becomes head after a dequeue; with a single entry left it can
  // only be the resolution arriving in the same cycle
  always_comb begin
    w_nxt_pc    = 32'd0;
    w_nxt_type  = 3'd0;
    w_nxt_taken = 1'b0;
    if (r_count > CW'(1)) begin
      w_nxt_pc    = r_q_pc[w_rd_nxt];
      w_nxt_type  = r_q_type[w_rd_nxt];
      w_nxt_taken = r_q_taken[w_rd_nxt];
    end else begin
      w_nxt_pc    = bus.res_pc;
      w_nxt_type  = bus.res_type;
      w_nxt_taken = bus.res_taken;
    end
  end

  // Queue pointers, occupancy, slot valid bits and the saturating drop counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_count    <= {CW{1'b0}};
      r_drop_cnt <= 8'd0;
      r_q_vld    <= {DEPTH{1'b0}};
    end else begin
      if (w_deq) begin
        r_rd_ptr          <= w_rd_nxt;
        r_q_vld[r_rd_ptr] <= 1'b0;
      end
      if (w_enq) begin
        r_wr_ptr          <= r_wr_ptr + AW'(1);
        r_q_vld[r_wr_ptr] <= 1'b1;
      end
      r_count <= w_cnt_nxt;
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  // Queue payload storage; occupancy is tracked by r_q_vld so no reset is needed
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_pc[r_wr_ptr]    <= bus.res_pc;
      r_q_type[r_wr_ptr]  <= bus.res_type;
      r_q_taken[r_wr_ptr] <= bus.res_taken;
      r_q_mis[r_wr_ptr]   <= bus.res_mispredict;
    end
  end

  // Issue FSM with registered update and rollback outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_hold_cnt  <= 3'd0;
      r_upd_valid <= 1'b0;
      r_upd_pc    <= 32'd0;
      r_upd_type  <= 3'd0;
      r_upd_taken <= 1'b0;
      r_rb_valid  <= 1'b0;
      r_rb_pc     <= 32'd0;
      r_rb_type   <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state     <= ISSUE;
            r_upd_valid <= 1'b1;
            r_upd_pc    <= w_head_pc;
            r_upd_type  <= w_head_type;
            r_upd_taken <= w_head_taken;
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE: begin
          if (bus.upd_ready) begin
            if (w_head_mis) begin
              r_state     <= ROLLBACK;
              r_upd_valid <= 1'b0;
              r_upd_pc    <= 32'd0;
              r_upd_type  <= 3'd0;
              r_upd_taken <= 1'b0;
              r_rb_valid  <= 1'b1;
              r_rb_pc     <= r_upd_pc;
              r_rb_type   <= r_upd_type;
            end else if (w_cnt_nxt != {CW{1'b0}}) begin
              r_state     <= ISSUE;
              r_upd_pc    <= w_nxt_pc;
              r_upd_type  <= w_nxt_type;
              r_upd_taken <= w_nxt_taken;
            end else begin
              r_state     <= IDLE;
              r_upd_valid <= 1'b0;
              r_upd_pc    <= 32'd0;
              r_upd_type  <= 3'd0;
              r_upd_taken <= 1'b0;
            end
          end else begin
            r_state <= ISSUE;
          end
        end
        ROLLBACK: begin
          r_state    <= HOLD;
          r_hold_cnt <= C_RB_WAIT;
          r_rb_valid <= 1'b0;
          r_rb_pc    <= 32'd0;
          r_rb_type  <= 3'd0;
        end
        HOLD: begin
          if (r_hold_cnt <= 3'd1) begin
            r_hold_cnt <= 3'd0;
            if (!w_empty) begin
              r_state     <= ISSUE;
              r_upd_valid <= 1'b1;
              r_upd_pc    <= w_head_pc;
              r_upd_type  <= w_head_type;
              r_upd_taken <= w_head_taken;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt - 3'd1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_hold_cnt  <= 3'd0;
          r_upd_valid <= 1'b0;
          r_upd_pc    <= 32'd0;
          r_upd_type  <= 3'd0;
          r_upd_taken <= 1'b0;
          r_rb_valid  <= 1'b0;
          r_rb_pc     <= 32'd0;
          r_rb_type   <= 3'd0;
        end
      endcase
    end
  end

  assign bus.upd_valid = r_upd_valid;
  assign bus.upd_pc    = r_upd_pc;
  assign bus.upd_type  = r_upd_type;
  assign bus.upd_taken = r_upd_taken;
  assign bus.rb_valid  = r_rb_valid;
  assign bus.rb_pc     = r_rb_pc;
  assign bus.rb_type   = r_rb_type;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.count     = r_count;
  assign bus.drop_cnt  = r_drop_cnt;
  assign bus.busy      = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed and random stimulus for bp_update_scheduler, checked every cycle
// against a queue-based reference model of the scheduling rules.
module tb_bp_update_scheduler;
  localparam int DEPTH   = 4;
  localparam int RB_WAIT = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bp_update_scheduler_if #(.DEPTH(DEPTH)) bus ();

  bp_update_scheduler #(.DEPTH(DEPTH), .RB_WAIT(RB_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  ty;
    logic        tk;
    logic        mis;
  } ent_t;

  // Reference model: pending entries, whether the front one is being offered,
  // a pending rollback pulse and the remaining quiet cycles after it
  ent_t mq[$];
  ent_t m_rbe;
  bit   m_offer;
  bit   m_rb;
  int   m_quiet;
  int   m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    ent_t e;
    ent_t n;
    bit   ok;
    bit   deq;
    bit   enq;
    bit   drop;
    int   pre;
    if (!rst_n) begin
      mq.delete();
      m_offer = 1'b0;
      m_rb    = 1'b0;
      m_quiet = 0;
      m_drop  = 0;
    end else begin
      pre  = mq.size();
      ok   = bus.res_valid && !bus.PL_stall && (bus.res_type <= 3'd5);
      deq  = m_offer && bus.upd_ready;
      enq  = ok && ((pre < DEPTH) || deq);
      drop = ok && (pre == DEPTH) && !deq;
      if (m_offer) begin
        if (deq) begin
          e = mq.pop_front();
          if (e.mis) begin
            m_offer = 1'b0;
            m_rb    = 1'b1;
            m_rbe   = e;
          end else begin
            m_offer = (mq.size() + int'(enq)) > 0;
          end
        end
      end else if (m_rb) begin
        m_rb    = 1'b0;
        m_quiet = RB_WAIT;
      end else if (m_quiet > 0) begin
        m_quiet--;
        if (m_quiet == 0) m_offer = (pre > 0);
      end else begin
        m_offer = (pre > 0);
      end
      if (enq) begin
        n.pc  = bus.res_pc;
        n.ty  = bus.res_type;
        n.tk  = bus.res_taken;
        n.mis = bus.res_mispredict;
        mq.push_back(n);
      end
      if (drop && (m_drop < 255)) m_drop++;
    end
  endtask

  task automatic compare_all();
    chk("upd_valid", 32'(bus.upd_valid), 32'(m_offer));
    chk("upd_pc",    bus.upd_pc,         m_offer ? mq[0].pc : 32'd0);
    chk("upd_type",  32'(bus.upd_type),  m_offer ? 32'(mq[0].ty) : 32'd0);
    chk("upd_taken", 32'(bus.upd_taken), m_offer ? 32'(mq[0].tk) : 32'd0);
    chk("rb_valid",  32'(bus.rb_valid),  32'(m_rb));
    chk("rb_pc",     bus.rb_pc,          m_rb ? m_rbe.pc : 32'd0);
    chk("rb_type",   32'(bus.rb_type),   m_rb ? 32'(m_rbe.ty) : 32'd0);
    chk("count",     32'(bus.count),     32'(mq.size()));
    chk("full",      32'(bus.full),      32'(mq.size() == DEPTH));
    chk("empty",     32'(bus.empty),     32'(mq.size() == 0));
    chk("drop_cnt",  32'(bus.drop_cnt),  32'(m_drop));
    chk("busy",      32'(bus.busy),      32'(m_offer || m_rb || (m_quiet > 0) || (mq.size() > 0)));
    chk("excl",      32'(bus.upd_valid & bus.rb_valid), 32'd0);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic res(input logic v, input logic st, input logic [31:0] pc,
                     input logic [2:0] ty, input logic tk, input logic mis);
    bus.res_valid      = v;
    bus.PL_stall       = st;
    bus.res_pc         = pc;
    bus.res_type       = ty;
    bus.res_taken      = tk;
    bus.res_mispredict = mis;
  endtask

  task automatic idle_in();
    res(1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.upd_ready = 1'b0;
    idle_in();
    #1;
    tick();
    tick();
    chk("rst_upd_valid", 32'(bus.upd_valid), 32'd0);
    chk("rst_empty",     32'(bus.empty),     32'd1);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    rst_n = 1'b1;

    // single update
    bus.upd_ready = 1'b1;
    res(1'b1, 1'b0, 32'h100, 3'd1, 1'b1, 1'b0);
    tick();
    chk("single_cnt", 32'(bus.count), 32'd1);
    chk("single_lat", 32'(bus.upd_valid), 32'd0);
    idle_in();
    tick();
    chk("single_valid", 32'(bus.upd_valid), 32'd1);
    chk("single_pc",    bus.upd_pc,          32'h100);
    chk("single_type",  32'(bus.upd_type),   32'd1);
    chk("single_taken", 32'(bus.upd_taken),  32'd1);
    tick();
    chk("single_done_empty", 32'(bus.empty), 32'd1);
    chk("single_done_busy",  32'(bus.busy),  32'd0);

    // backpressure
    bus.upd_ready = 1'b0;
    res(1'b1, 1'b0, 32'h140, 3'd3, 1'b0, 1'b0);
    tick();
    idle_in();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(bus.upd_valid), 32'd1);
      chk("bp_pc",    bus.upd_pc,         32'h140);
      chk("bp_type",  32'(bus.upd_type),  32'd3);
    end
    bus.upd_ready = 1'b1;
    tick();
    chk("bp_deq_empty", 32'(bus.empty), 32'd1);

    // full and drop
    bus.upd_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      res(1'b1, 1'b0, 32'h400 + 32'(i * 4), 3'(i % 6), 1'(i % 2), 1'b0);
      tick();
    end
    chk("full_flag", 32'(bus.full),     32'd1);
    chk("full_cnt",  32'(bus.count),    32'd4);
    chk("full_drop", 32'(bus.drop_cnt), 32'd2);
    bus.upd_ready = 1'b1;
    res(1'b1, 1'b0, 32'h480, 3'd5, 1'b1, 1'b0);
    tick();
    chk("full_swap_cnt",  32'(bus.count),    32'd4);
    chk("full_swap_drop", 32'(bus.drop_cnt), 32'd2);
    chk("full_swap_head", bus.upd_pc,        32'h404);
    idle_in();
    for (int i = 0; i < 6; i++) tick();
    chk("full_drained", 32'(bus.empty), 32'd1);

    // rollback sequence
    bus.upd_ready = 1'b1;
    res(1'b1, 1'b0, 32'h200, 3'd2, 1'b0, 1'b1);
    tick();
    res(1'b1, 1'b0, 32'h300, 3'd0, 1'b1, 1'b0);
    tick();
    chk("rb_upd_pc", bus.upd_pc, 32'h200);
    idle_in();
    tick();
    chk("rb_pulse",    32'(bus.rb_valid),  32'd1);
    chk("rb_pulse_pc", bus.rb_pc,          32'h200);
    chk("rb_pulse_ty", 32'(bus.rb_type),   32'd2);
    chk("rb_no_upd",   32'(bus.upd_valid), 32'd0);
    tick();
    chk("rb_quiet1", 32'(bus.upd_valid | bus.rb_valid), 32'd0);
    tick();
    chk("rb_quiet2", 32'(bus.upd_valid | bus.rb_valid), 32'd0);
    tick();
    chk("rb_next_valid", 32'(bus.upd_valid), 32'd1);
    chk("rb_next_pc",    bus.upd_pc,         32'h300);
    tick();

    // stall and illegal type
    bus.upd_ready = 1'b0;
    res(1'b1, 1'b0, 32'h600, 3'd4, 1'b0, 1'b0);
    tick();
    res(1'b1, 1'b1, 32'h604, 3'd0, 1'b0, 1'b0);
    tick();
    chk("stall_cnt",  32'(bus.count),    32'd1);
    chk("stall_drop", 32'(bus.drop_cnt), 32'd2);
    res(1'b1, 1'b0, 32'h608, 3'd7, 1'b0, 1'b0);
    tick();
    chk("illegal_cnt",  32'(bus.count),    32'd1);
    chk("illegal_drop", 32'(bus.drop_cnt), 32'd2);
    idle_in();
    bus.upd_ready = 1'b1;
    tick();

    // reset during the quiet window
    bus.upd_ready = 1'b0;
    res(1'b1, 1'b0, 32'h500, 3'd1, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      res(1'b1, 1'b0, 32'h510 + 32'(i * 4), 3'd0, 1'b1, 1'b0);
      tick();
    end
    idle_in();
    bus.upd_ready = 1'b1;
    tick();
    chk("hold_rb", 32'(bus.rb_valid), 32'd1);
    bus.upd_ready = 1'b0;
    tick();
    chk("hold_cnt", 32'(bus.count), 32'd3);
    rst_n = 1'b0;
    tick();
    chk("hold_rst_cnt",  32'(bus.count),    32'd0);
    chk("hold_rst_busy", 32'(bus.busy),     32'd0);
    chk("hold_rst_drop", 32'(bus.drop_cnt), 32'd0);
    rst_n = 1'b1;
    bus.upd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("hold_rst_quiet", 32'(bus.upd_valid | bus.rb_valid), 32'd0);
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      res(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), $urandom(),
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      bus.upd_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
